// File: rtl/window_stream_buffer.sv
// Raster pixel stream in, bordered WIN_H x WIN_W neighbourhood plus centre coordinates out.
// Outputs register one clk after the completing en cycle; no backpressure, en low freezes everything.
module window_stream_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int WIN_W        = 3,
  parameter int WIN_H        = 3,
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int LOC_WIDTH    = 11,
  parameter int BORDER_MODE  = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic [DATA_WIDTH-1:0]             data_in,
  output logic [WIN_H*WIN_W*DATA_WIDTH-1:0] window,
  output logic                              win_valid,
  output logic [LOC_WIDTH-1:0]              win_x,
  output logic [LOC_WIDTH-1:0]              win_y
);
  localparam int RW    = (WIN_W - 1) / 2;
  localparam int RH    = (WIN_H - 1) / 2;
  localparam int PRIME = RH * FRAME_WIDTH + RW;
  localparam int AW    = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int PW    = $clog2(PRIME + 1);

  typedef logic [DATA_WIDTH-1:0] pix_t;

  logic [LOC_WIDTH-1:0] col, row;
  logic [AW-1:0]        addr;
  logic [PW-1:0]        prime_cnt;
  logic                 primed;
  logic                 col_last, row_last;

  pix_t line_mem [WIN_H-1][FRAME_WIDTH];
  pix_t shreg    [WIN_H][WIN_W];
  pix_t vcol     [WIN_H];
  pix_t sh_nx    [WIN_H][WIN_W];

  logic                             wrap_x;
  logic [LOC_WIDTH-1:0]             ry, cx_nx, cy_nx;
  logic [WIN_H*WIN_W*DATA_WIDTH-1:0] win_nx;

  assign col_last = (col == LOC_WIDTH'(FRAME_WIDTH - 1));
  assign row_last = (row == LOC_WIDTH'(FRAME_HEIGHT - 1));

  // Column vector at the current column: vcol[k] is the pixel k rows above the incoming one.
  always_comb begin
    vcol[0] = data_in;
    for (int k = 1; k < WIN_H; k++) vcol[k] = line_mem[k-1][addr];
  end

  always_comb begin
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W - 1; c++) sh_nx[r][c] = shreg[r][c+1];
      sh_nx[r][WIN_W-1] = vcol[WIN_H-1-r];
    end
  end

  // Centres whose column wraps into the previous row also step back one row.
  assign wrap_x = (col < LOC_WIDTH'(RW));
  assign cx_nx  = wrap_x ? col + LOC_WIDTH'(FRAME_WIDTH - RW) : col - LOC_WIDTH'(RW);
  assign ry     = LOC_WIDTH'(RH) + {{(LOC_WIDTH-1){1'b0}}, wrap_x};
  assign cy_nx  = (row < ry) ? row + LOC_WIDTH'(FRAME_HEIGHT) - ry : row - ry;

  always_comb begin
    win_nx = '0;
    for (int r = 0; r < WIN_H; r++) begin
      for (int c = 0; c < WIN_W; c++) begin
        int   xi, yi, sr, sc;
        logic oob;
        xi  = int'(cx_nx) + c - RW;
        yi  = int'(cy_nx) + r - RH;
        sc  = c;
        sr  = r;
        oob = 1'b0;
        if (xi < 0) begin
          sc  = RW - int'(cx_nx);
          oob = 1'b1;
        end else if (xi > FRAME_WIDTH - 1) begin
          sc  = RW + FRAME_WIDTH - 1 - int'(cx_nx);
          oob = 1'b1;
        end
        if (yi < 0) begin
          sr  = RH - int'(cy_nx);
          oob = 1'b1;
        end else if (yi > FRAME_HEIGHT - 1) begin
          sr  = RH + FRAME_HEIGHT - 1 - int'(cy_nx);
          oob = 1'b1;
        end
        // Zero mode drops out-of-frame taps; replicate reads the clamped in-window tap.
        if (!(oob && BORDER_MODE == 0)) begin
          for (int a = 0; a < WIN_H; a++)
            for (int b = 0; b < WIN_W; b++)
              if (a == sr && b == sc)
                win_nx[(r*WIN_W+c)*DATA_WIDTH +: DATA_WIDTH] = sh_nx[a][b];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col       <= '0;
      row       <= '0;
      addr      <= '0;
      prime_cnt <= '0;
      primed    <= 1'b0;
      window    <= '0;
      win_valid <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
    end else if (en) begin
      col  <= col_last ? '0 : col + LOC_WIDTH'(1);
      addr <= col_last ? '0 : addr + AW'(1);
      if (col_last) row <= row_last ? '0 : row + LOC_WIDTH'(1);
      if (!primed) begin
        prime_cnt <= prime_cnt + PW'(1);
        if (prime_cnt == PW'(PRIME - 1)) primed <= 1'b1;
      end
      window    <= win_nx;
      win_valid <= primed;
      win_x     <= cx_nx;
      win_y     <= cy_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (en && !reset) begin
      for (int k = 0; k < WIN_H - 1; k++) line_mem[k][addr] <= vcol[k];
      for (int r = 0; r < WIN_H; r++)
        for (int c = 0; c < WIN_W; c++) shreg[r][c] <= sh_nx[r][c];
    end
  end

endmodule

// File: tb/tb_window_stream_buffer.sv
// Bench: three buffers (3x3 zero, 3x3 replicate, 5x5 zero) on one stream, checked against a pixel-history model.
module tb_window_stream_buffer;
  localparam int W  = 8;
  localparam int HA = 4;
  localparam int HC = 6;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [7:0]   data_in = '0;

  logic [71:0]  win_a, win_b;
  logic [199:0] win_c;
  logic         val_a, val_b, val_c;
  logic [10:0]  x_a, y_a, x_b, y_b, x_c, y_c;

  window_stream_buffer #(.DATA_WIDTH(8), .WIN_W(3), .WIN_H(3), .FRAME_WIDTH(W),
    .FRAME_HEIGHT(HA), .LOC_WIDTH(11), .BORDER_MODE(0)) u_z33 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .window(win_a), .win_valid(val_a), .win_x(x_a), .win_y(y_a));

  window_stream_buffer #(.DATA_WIDTH(8), .WIN_W(3), .WIN_H(3), .FRAME_WIDTH(W),
    .FRAME_HEIGHT(HA), .LOC_WIDTH(11), .BORDER_MODE(1)) u_r33 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .window(win_b), .win_valid(val_b), .win_x(x_b), .win_y(y_b));

  window_stream_buffer #(.DATA_WIDTH(8), .WIN_W(5), .WIN_H(5), .FRAME_WIDTH(W),
    .FRAME_HEIGHT(HC), .LOC_WIDTH(11), .BORDER_MODE(0)) u_z55 (
    .clk(clk), .reset(reset), .en(en), .data_in(data_in),
    .window(win_c), .win_valid(val_c), .win_x(x_c), .win_y(y_c));

  always #5 clk = ~clk;

  int c_rh[3]   = '{1, 1, 2};
  int c_rw[3]   = '{1, 1, 2};
  int c_h[3]    = '{HA, HA, HC};
  int c_mode[3] = '{0, 1, 0};

  logic [7:0]   hist[$];
  logic [199:0] e_win[3];
  logic         e_val[3];
  logic         e_known[3];
  logic [10:0]  e_x[3], e_y[3];
  bit           pattern_run = 1'b0;
  int           n_checks = 0;
  int           n_pass = 0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Window centred on the pixel accepted (rh*W+rw) pixels earlier, read from the pixel history.
  function automatic logic [199:0] model_win(input int rh, input int rw, input int h,
                                             input int mode, input int n);
    logic [199:0] v;
    int m, fs, cm, cx, cy, x, y, xc, yc, idx, ww;
    v  = '0;
    ww = 2 * rw + 1;
    fs = W * h;
    m  = n - (rh * W + rw);
    cm = ((m % fs) + fs) % fs;
    cx = cm % W;
    cy = cm / W;
    for (int r = 0; r <= 2 * rh; r++) begin
      for (int c = 0; c <= 2 * rw; c++) begin
        x  = cx + c - rw;
        y  = cy + r - rh;
        xc = (x < 0) ? 0 : ((x > W - 1) ? W - 1 : x);
        yc = (y < 0) ? 0 : ((y > h - 1) ? h - 1 : y);
        if (!((xc != x || yc != y) && mode == 0)) begin
          idx = m + (yc - cy) * W + (xc - cx);
          if (idx >= 0 && idx < hist.size()) v[(r*ww+c)*8 +: 8] = hist[idx];
        end
      end
    end
    return v;
  endfunction

  function automatic logic [199:0] pk(input int a0, input int a1, input int a2,
                                      input int a3, input int a4, input int a5,
                                      input int a6, input int a7, input int a8);
    int t[9];
    logic [199:0] v;
    t = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
    v = '0;
    for (int i = 0; i < 9; i++) v[i*8 +: 8] = 8'(t[i]);
    return v;
  endfunction

  task automatic update_model(input logic r, input logic e);
    int n, m, fs, cm;
    if (r) begin
      hist.delete();
      for (int i = 0; i < 3; i++) begin
        e_win[i] = '0; e_val[i] = 1'b0; e_x[i] = '0; e_y[i] = '0; e_known[i] = 1'b1;
      end
    end else if (e) begin
      hist.push_back(data_in);
      n = hist.size() - 1;
      for (int i = 0; i < 3; i++) begin
        fs = W * c_h[i];
        m  = n - (c_rh[i] * W + c_rw[i]);
        cm = ((m % fs) + fs) % fs;
        e_x[i]     = 11'(cm % W);
        e_y[i]     = 11'(cm / W);
        e_val[i]   = (m >= 0);
        e_known[i] = (m >= 0);
        e_win[i]   = model_win(c_rh[i], c_rw[i], c_h[i], c_mode[i], n);
      end
    end
  endtask

  task automatic chk_dut(input string nm, input int i, input logic [199:0] w,
                         input logic v, input logic [10:0] x, input logic [10:0] y);
    chk($sformatf("%s_valid", nm), {199'b0, v}, {199'b0, e_val[i]});
    chk($sformatf("%s_x", nm), {189'b0, x}, {189'b0, e_x[i]});
    chk($sformatf("%s_y", nm), {189'b0, y}, {189'b0, e_y[i]});
    if (e_known[i]) chk($sformatf("%s_window", nm), w, e_win[i]);
  endtask

  // Spot checks of hand-derived windows while the stream is data = row*8+col.
  task automatic directed();
    int n;
    n = hist.size() - 1;
    if (n == 8) chk("first_valid_early", {199'b0, val_a}, 200'd0);
    if (n == 9) chk("first_valid_on", {199'b0, val_a}, 200'd1);
    if (e_val[0] && e_x[0] == 0 && e_y[0] == 0)
      chk("z33_centre_0_0", {128'b0, win_a}, pk(0, 0, 0, 0, 0, 1, 0, 8, 9));
    if (e_val[0] && e_x[0] == 3 && e_y[0] == 2)
      chk("z33_centre_3_2", {128'b0, win_a}, pk(10, 11, 12, 18, 19, 20, 26, 27, 28));
    if (e_val[0] && e_x[0] == 7 && e_y[0] == 3)
      chk("z33_centre_7_3", {128'b0, win_a}, pk(22, 23, 0, 30, 31, 0, 0, 0, 0));
    if (e_val[1] && e_x[1] == 0 && e_y[1] == 0)
      chk("r33_centre_0_0", {128'b0, win_b}, pk(0, 0, 1, 0, 0, 1, 8, 8, 9));
    if (e_val[1] && e_x[1] == 7 && e_y[1] == 3)
      chk("r33_centre_7_3", {128'b0, win_b}, pk(22, 23, 23, 30, 31, 31, 30, 31, 31));
  endtask

  task automatic step(input logic e, input logic [7:0] d, input logic r);
    en      = e;
    data_in = d;
    reset   = r;
    @(posedge clk);
    #1;
    update_model(r, e);
    chk_dut("z33", 0, {128'b0, win_a}, val_a, x_a, y_a);
    chk_dut("r33", 1, {128'b0, win_b}, val_b, x_b, y_b);
    chk_dut("z55", 2, win_c, val_c, x_c, y_c);
    if (pattern_run && e && !r) directed();
  endtask

  initial begin
    step(1'b0, 8'd0, 1'b1);
    step(1'b0, 8'd0, 1'b1);

    pattern_run = 1'b1;
    for (int k = 0; k < 80; k++) step(1'b1, 8'(k % 32), 1'b0);
    pattern_run = 1'b0;

    // Mid-frame reset coinciding with en: that pixel is dropped and priming restarts.
    for (int k = 0; k < 20; k++) step(1'b1, 8'($urandom), 1'b0);
    step(1'b1, 8'($urandom), 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 8'($urandom), 1'b0);

    for (int k = 0; k < 400; k++) step($urandom_range(0, 9) < 3, 8'($urandom), 1'b0);

    step(1'b0, 8'($urandom), 1'b1);
    for (int k = 0; k < 60; k++) step($urandom_range(0, 9) < 3, 8'($urandom), 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
